// File: rtl/rs_age_station_if.sv
// Insert, CDB snoop and dual-lane dispatch bundle
// for the age-ordered reservation station.
interface rs_age_station_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int CTRL_W = 9
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [TAG_W-1:0]  in_dest;
  logic [DATA_W-1:0] in_v1;
  logic [DATA_W-1:0] in_v2;
  logic              in_r1;
  logic              in_r2;
  logic [TAG_W-1:0]  in_t1;
  logic [TAG_W-1:0]  in_t2;

  logic              cdb0_valid;
  logic [TAG_W-1:0]  cdb0_tag;
  logic [DATA_W-1:0] cdb0_data;
  logic              cdb1_valid;
  logic [TAG_W-1:0]  cdb1_tag;
  logic [DATA_W-1:0] cdb1_data;

  logic              d0_valid;
  logic              d0_ready;
  logic [CTRL_W-1:0] d0_ctrl;
  logic [TAG_W-1:0]  d0_dest;
  logic [DATA_W-1:0] d0_op1;
  logic [DATA_W-1:0] d0_op2;
  logic              d1_valid;
  logic              d1_ready;
  logic [CTRL_W-1:0] d1_ctrl;
  logic [TAG_W-1:0]  d1_dest;
  logic [DATA_W-1:0] d1_op1;
  logic [DATA_W-1:0] d1_op2;

  modport master (
    output in_valid, in_ctrl, in_dest,
    output in_v1, in_v2, in_r1, in_r2,
    output in_t1, in_t2,
    input  in_ready,
    output cdb0_valid, cdb0_tag, cdb0_data,
    output cdb1_valid, cdb1_tag, cdb1_data,
    input  d0_valid, d0_ctrl, d0_dest,
    input  d0_op1, d0_op2,
    output d0_ready,
    input  d1_valid, d1_ctrl, d1_dest,
    input  d1_op1, d1_op2,
    output d1_ready
  );

  modport slave (
    input  in_valid, in_ctrl, in_dest,
    input  in_v1, in_v2, in_r1, in_r2,
    input  in_t1, in_t2,
    output in_ready,
    input  cdb0_valid, cdb0_tag, cdb0_data,
    input  cdb1_valid, cdb1_tag, cdb1_data,
    output d0_valid, d0_ctrl, d0_dest,
    output d0_op1, d0_op2,
    input  d0_ready,
    output d1_valid, d1_ctrl, d1_dest,
    output d1_op1, d1_op2,
    input  d1_ready
  );
endinterface

// File: rtl/rs_age_station.sv
// Age-ordered reservation station: CDB wakeup with
// insert bypass, oldest-first dual dispatch, flush.
module rs_age_station #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int CTRL_W = 9,
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  rs_age_station_if.slave  io,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int IDX_W = $clog2(DEPTH);
  typedef logic [IDX_W-1:0] idx_t;

  logic [DEPTH-1:0]  busy, rdy1, rdy2;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [TAG_W-1:0]  dest_q [DEPTH];
  logic [TAG_W-1:0]  tag1_q [DEPTH];
  logic [TAG_W-1:0]  tag2_q [DEPTH];
  logic [DATA_W-1:0] val1_q [DEPTH];
  logic [DATA_W-1:0] val2_q [DEPTH];
  // older[i][j] set when entry i was issued before j
  logic [DEPTH-1:0]  older  [DEPTH];

  logic [DEPTH-1:0]  elig, sel0, sel1, clr;
  logic [DEPTH-1:0]  oe [DEPTH];
  idx_t              idx0, idx1, fidx;
  logic              v0, v1, f0, f1, ins;
  logic              b1_rdy, b2_rdy;
  logic [DATA_W-1:0] b1_val, b2_val;

  function automatic logic hit(
    input logic             v,
    input logic [TAG_W-1:0] a,
    input logic [TAG_W-1:0] b
  );
    return v && (a == b);
  endfunction

  assign elig = busy & rdy1 & rdy2;

  // rank = number of older eligible entries
  always_comb begin
    sel0 = '0;
    sel1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      oe[i] = '0;
      for (int j = 0; j < DEPTH; j++)
        oe[i][j] = elig[j] & older[j][i];
      sel0[i] = elig[i] & (oe[i] == '0);
      sel1[i] = elig[i] & (oe[i] != '0) &
        ((oe[i] & (oe[i] - DEPTH'(1))) == '0);
    end
  end

  always_comb begin
    idx0 = '0;
    idx1 = '0;
    fidx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (sel0[i]) idx0 = idx_t'(i);
      if (sel1[i]) idx1 = idx_t'(i);
      if (!busy[i]) fidx = idx_t'(i);
    end
  end

  assign v0 = |sel0;
  assign v1 = |sel1;
  assign io.d0_valid = v0;
  assign io.d0_ctrl  = v0 ? ctrl_q[idx0] : '0;
  assign io.d0_dest  = v0 ? dest_q[idx0] : '0;
  assign io.d0_op1   = v0 ? val1_q[idx0] : '0;
  assign io.d0_op2   = v0 ? val2_q[idx0] : '0;
  assign io.d1_valid = v1;
  assign io.d1_ctrl  = v1 ? ctrl_q[idx1] : '0;
  assign io.d1_dest  = v1 ? dest_q[idx1] : '0;
  assign io.d1_op1   = v1 ? val1_q[idx1] : '0;
  assign io.d1_op2   = v1 ? val2_q[idx1] : '0;

  assign f0  = v0 & io.d0_ready;
  assign f1  = v1 & io.d1_ready;
  assign clr = ({DEPTH{f0}} & sel0) |
               ({DEPTH{f1}} & sel1);

  assign full        = count == CNT_W'(DEPTH);
  assign empty       = count == '0;
  assign io.in_ready = ~full;
  assign ins = io.in_valid & ~full & ~flush;

  always_comb begin
    b1_rdy = 1'b1;
    b1_val = io.in_v1;
    b2_rdy = 1'b1;
    b2_val = io.in_v2;
    if (!io.in_r1) begin
      if (hit(io.cdb0_valid, io.cdb0_tag, io.in_t1))
        b1_val = io.cdb0_data;
      else if (hit(io.cdb1_valid, io.cdb1_tag, io.in_t1))
        b1_val = io.cdb1_data;
      else
        b1_rdy = 1'b0;
    end
    if (!io.in_r2) begin
      if (hit(io.cdb0_valid, io.cdb0_tag, io.in_t2))
        b2_val = io.cdb0_data;
      else if (hit(io.cdb1_valid, io.cdb1_tag, io.in_t2))
        b2_val = io.cdb1_data;
      else
        b2_rdy = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy  <= '0;
      rdy1  <= '0;
      rdy2  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= '0;
        dest_q[i] <= '0;
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
        val1_q[i] <= '0;
        val2_q[i] <= '0;
        older[i]  <= '0;
      end
    end else if (flush) begin
      busy  <= '0;
      rdy1  <= '0;
      rdy2  <= '0;
      count <= '0;
    end else begin
      count <= count + CNT_W'(ins)
             - CNT_W'(f0) - CNT_W'(f1);
      for (int i = 0; i < DEPTH; i++) begin
        if (clr[i]) begin
          busy[i] <= 1'b0;
          rdy1[i] <= 1'b0;
          rdy2[i] <= 1'b0;
        end else if (busy[i]) begin
          if (!rdy1[i]) begin
            if (hit(io.cdb0_valid, io.cdb0_tag, tag1_q[i])) begin
              rdy1[i]   <= 1'b1;
              val1_q[i] <= io.cdb0_data;
            end else if (hit(io.cdb1_valid, io.cdb1_tag, tag1_q[i])) begin
              rdy1[i]   <= 1'b1;
              val1_q[i] <= io.cdb1_data;
            end
          end
          if (!rdy2[i]) begin
            if (hit(io.cdb0_valid, io.cdb0_tag, tag2_q[i])) begin
              rdy2[i]   <= 1'b1;
              val2_q[i] <= io.cdb0_data;
            end else if (hit(io.cdb1_valid, io.cdb1_tag, tag2_q[i])) begin
              rdy2[i]   <= 1'b1;
              val2_q[i] <= io.cdb1_data;
            end
          end
        end
        if (ins && fidx == idx_t'(i)) begin
          busy[i]   <= 1'b1;
          rdy1[i]   <= b1_rdy;
          rdy2[i]   <= b2_rdy;
          ctrl_q[i] <= io.in_ctrl;
          dest_q[i] <= io.in_dest;
          tag1_q[i] <= io.in_t1;
          tag2_q[i] <= io.in_t2;
          val1_q[i] <= b1_val;
          val2_q[i] <= b2_val;
          older[i]  <= '0;
        end
        // every occupied entry is older than the newcomer
        if (ins) older[i][fidx] <= busy[i];
      end
    end
  end
endmodule

// File: tb/tb_rs_age_station.sv
// Bench for rs_age_station: vector table, directed
// corner sequences and random run against a queue model.
module tb_rs_age_station;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 5;
  localparam int CTRL_W = 9;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  int               tests = 0;
  int               fails = 0;

  rs_age_station_if #(
    .DATA_W(DATA_W), .TAG_W(TAG_W), .CTRL_W(CTRL_W)
  ) bus ();

  rs_age_station #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W),
    .CTRL_W(CTRL_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .io(bus),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [TAG_W-1:0]  dest;
    logic              r1;
    logic [TAG_W-1:0]  t1;
    logic [DATA_W-1:0] v1;
    logic              r2;
    logic [TAG_W-1:0]  t2;
    logic [DATA_W-1:0] v2;
  } me_t;

  me_t mq[$];

  typedef struct {
    logic       iv;
    logic [4:0] dest;
    logic       d0r;
    logic       d1r;
    int         cnt;
    logic       fu;
    logic       v0;
    logic [4:0] q0;
    logic       v1;
    logic [4:0] q1;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 1'b0;
    bus.in_valid = 0; bus.in_ctrl = '0; bus.in_dest = '0;
    bus.in_v1 = '0; bus.in_v2 = '0;
    bus.in_r1 = 0; bus.in_r2 = 0;
    bus.in_t1 = '0; bus.in_t2 = '0;
    bus.cdb0_valid = 0; bus.cdb0_tag = '0; bus.cdb0_data = '0;
    bus.cdb1_valid = 0; bus.cdb1_tag = '0; bus.cdb1_data = '0;
    bus.d0_ready = 0; bus.d1_ready = 0;
  endtask

  task automatic put(input logic [4:0] d,
                     input logic r1, input logic [4:0] t1,
                     input logic [31:0] v1,
                     input logic r2, input logic [4:0] t2,
                     input logic [31:0] v2);
    bus.in_valid = 1;
    bus.in_ctrl = CTRL_W'(d);
    bus.in_dest = d;
    bus.in_r1 = r1; bus.in_t1 = t1; bus.in_v1 = v1;
    bus.in_r2 = r2; bus.in_t2 = t2; bus.in_v2 = v2;
  endtask

  // reference: an operand waiting on a tag takes the first CDB that carries it
  function automatic me_t wk(input me_t e);
    me_t o = e;
    if (!o.r1) begin
      if (bus.cdb0_valid && bus.cdb0_tag == o.t1) begin
        o.r1 = 1; o.v1 = bus.cdb0_data;
      end else if (bus.cdb1_valid && bus.cdb1_tag == o.t1) begin
        o.r1 = 1; o.v1 = bus.cdb1_data;
      end
    end
    if (!o.r2) begin
      if (bus.cdb0_valid && bus.cdb0_tag == o.t2) begin
        o.r2 = 1; o.v2 = bus.cdb0_data;
      end else if (bus.cdb1_valid && bus.cdb1_tag == o.t2) begin
        o.r2 = 1; o.v2 = bus.cdb1_data;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] pay(input me_t e);
    return 128'({e.ctrl, e.dest, e.v1, e.v2});
  endfunction

  task automatic pred(output int e0, output int e1);
    e0 = -1;
    e1 = -1;
    for (int k = 0; k < mq.size(); k++)
      if (mq[k].r1 && mq[k].r2) begin
        if (e0 < 0) e0 = k;
        else if (e1 < 0) e1 = k;
      end
  endtask

  task automatic model_step(input int e0, input int e1);
    int  n;
    me_t e;
    n = mq.size();
    if (flush) begin
      mq.delete();
    end else begin
      if (e1 >= 0 && bus.d1_ready) mq.delete(e1);
      if (e0 >= 0 && bus.d0_ready) mq.delete(e0);
      for (int k = 0; k < mq.size(); k++) mq[k] = wk(mq[k]);
      if (bus.in_valid && n < DEPTH) begin
        e.ctrl = bus.in_ctrl; e.dest = bus.in_dest;
        e.r1 = bus.in_r1; e.t1 = bus.in_t1; e.v1 = bus.in_v1;
        e.r2 = bus.in_r2; e.t2 = bus.in_t2; e.v2 = bus.in_v2;
        mq.push_back(wk(e));
      end
    end
  endtask

  initial begin
    int          e0, e1;
    me_t         x0, x1;
    logic [127:0] p0;
    int          sc[3];
    logic        sv[3];

    tv[0] = '{1, 5'd1, 0, 0, 1, 0, 1, 5'd1, 0, 5'd0};
    tv[1] = '{1, 5'd2, 0, 0, 2, 0, 1, 5'd1, 1, 5'd2};
    tv[2] = '{1, 5'd3, 0, 0, 3, 0, 1, 5'd1, 1, 5'd2};
    tv[3] = '{1, 5'd4, 0, 0, 4, 1, 1, 5'd1, 1, 5'd2};
    tv[4] = '{1, 5'd5, 0, 0, 4, 1, 1, 5'd1, 1, 5'd2};
    tv[5] = '{0, 5'd0, 1, 1, 2, 0, 1, 5'd3, 1, 5'd4};
    tv[6] = '{0, 5'd0, 1, 0, 1, 0, 1, 5'd4, 0, 5'd0};
    tv[7] = '{0, 5'd0, 1, 1, 0, 0, 0, 5'd0, 0, 5'd0};

    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_d0_valid", bus.d0_valid, 0);
    chk("rst_d1_valid", bus.d1_valid, 0);
    chk("rst_d0_pay", {bus.d0_ctrl, bus.d0_dest, bus.d0_op1, bus.d0_op2}, 0);
    rst = 1'b1;
    tick();

    for (int k = 0; k < 8; k++) begin
      idle();
      if (tv[k].iv)
        put(tv[k].dest, 1, 0, 32'(tv[k].dest), 1, 0, ~32'(tv[k].dest));
      bus.d0_ready = tv[k].d0r;
      bus.d1_ready = tv[k].d1r;
      tick();
      chk($sformatf("vec%0d_count", k), count, tv[k].cnt);
      chk($sformatf("vec%0d_full", k), full, tv[k].fu);
      chk($sformatf("vec%0d_in_ready", k), bus.in_ready, !tv[k].fu);
      chk($sformatf("vec%0d_d0v", k), bus.d0_valid, tv[k].v0);
      chk($sformatf("vec%0d_d0dest", k), bus.d0_dest, tv[k].q0);
      chk($sformatf("vec%0d_d1v", k), bus.d1_valid, tv[k].v1);
      chk($sformatf("vec%0d_d1dest", k), bus.d1_dest, tv[k].q1);
    end
    idle();

    put(7, 0, 9, 0, 1, 0, 32'h55);
    tick(); idle();
    chk("wake_wait0", bus.d0_valid, 0);
    tick();
    chk("wake_wait1", bus.d0_valid, 0);
    bus.cdb1_valid = 1; bus.cdb1_tag = 9; bus.cdb1_data = 32'hDEADBEEF;
    tick(); idle();
    chk("wake_valid", bus.d0_valid, 1);
    chk("wake_op1", bus.d0_op1, 32'hDEADBEEF);
    chk("wake_dest", bus.d0_dest, 7);
    bus.d0_ready = 1;
    tick(); idle();
    chk("wake_drain", count, 0);

    put(8, 1, 0, 32'h11, 0, 5, 0);
    bus.cdb0_valid = 1; bus.cdb0_tag = 5; bus.cdb0_data = 32'h1234;
    bus.cdb1_valid = 1; bus.cdb1_tag = 5; bus.cdb1_data = 32'h5555;
    tick(); idle();
    chk("byp_valid", bus.d0_valid, 1);
    chk("byp_op2", bus.d0_op2, 32'h1234);
    chk("byp_op1", bus.d0_op1, 32'h11);
    bus.d0_ready = 1;
    tick(); idle();

    put(10, 0, 3, 0, 1, 0, 32'hA);
    tick(); idle();
    put(11, 1, 0, 32'hB, 1, 0, 32'hB);
    tick(); idle();
    chk("age_b_first", bus.d0_dest, 11);
    chk("age_b_alone", bus.d1_valid, 0);
    bus.d0_ready = 1;
    put(12, 1, 0, 32'hC, 1, 0, 32'hC);
    bus.cdb0_valid = 1; bus.cdb0_tag = 3; bus.cdb0_data = 32'hA1;
    tick(); idle();
    chk("age_a_d0", bus.d0_dest, 10);
    chk("age_a_op1", bus.d0_op1, 32'hA1);
    chk("age_c_d1", bus.d1_dest, 12);
    chk("age_count", count, 2);
    bus.d0_ready = 1; bus.d1_ready = 1;
    tick(); idle();
    chk("age_drain", count, 0);

    for (int k = 0; k < 3; k++) begin
      put(5'(20 + k), 1, 0, 32'(100 + k), 1, 0, 32'(200 + k));
      tick(); idle();
    end
    chk("stall_count", count, 3);
    chk("stall_d1_first", bus.d1_dest, 21);
    p0 = 128'({bus.d0_ctrl, bus.d0_dest, bus.d0_op1, bus.d0_op2});
    sc[0] = 2; sc[1] = 1; sc[2] = 1;
    sv[0] = 1; sv[1] = 0; sv[2] = 0;
    for (int c = 0; c < 3; c++) begin
      bus.d1_ready = 1;
      tick();
      chk($sformatf("stall%0d_d0_pay", c),
          {bus.d0_ctrl, bus.d0_dest, bus.d0_op1, bus.d0_op2}, p0);
      chk($sformatf("stall%0d_d0v", c), bus.d0_valid, 1);
      chk($sformatf("stall%0d_count", c), count, sc[c]);
      chk($sformatf("stall%0d_d1v", c), bus.d1_valid, sv[c]);
    end
    chk("stall_d1_next", bus.d1_dest, 0);
    idle();
    bus.d0_ready = 1;
    tick(); idle();

    for (int k = 0; k < 3; k++) begin
      put(5'(30 + k), 1, 0, 1, 1, 0, 2);
      tick(); idle();
    end
    chk("flush_pre_count", count, 3);
    flush = 1; bus.d0_ready = 1; bus.d1_ready = 1;
    put(33, 1, 0, 1, 1, 0, 2);
    tick(); idle();
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_d0v", bus.d0_valid, 0);
    chk("flush_d1v", bus.d1_valid, 0);
    tick();
    chk("flush_stays_empty", count, 0);

    put(40, 1, 0, 4, 1, 0, 4);
    tick();
    put(41, 0, 2, 0, 1, 0, 5);
    tick(); idle();
    chk("arst_pre_d0v", bus.d0_valid, 1);
    bus.cdb0_valid = 1; bus.cdb0_tag = 2; bus.cdb0_data = 32'h99;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_in_ready", bus.in_ready, 1);
    chk("arst_d0v", bus.d0_valid, 0);
    chk("arst_d1v", bus.d1_valid, 0);
    chk("arst_d0_pay", {bus.d0_ctrl, bus.d0_dest, bus.d0_op1, bus.d0_op2}, 0);
    tick();
    chk("arst_hold_d0v", bus.d0_valid, 0);
    idle();
    rst = 1'b1;
    tick();
    chk("arst_rel_count", count, 0);
    chk("arst_rel_d0v", bus.d0_valid, 0);

    mq.delete();
    for (int cyc = 0; cyc < 500; cyc++) begin
      pred(e0, e1);
      x0 = (e0 >= 0) ? mq[e0] : x0;
      x1 = (e1 >= 0) ? mq[e1] : x1;
      chk("rnd_d0v", bus.d0_valid, e0 >= 0);
      chk("rnd_d0_pay",
          128'({bus.d0_ctrl, bus.d0_dest, bus.d0_op1, bus.d0_op2}),
          (e0 >= 0) ? pay(x0) : 128'(0));
      chk("rnd_d1v", bus.d1_valid, e1 >= 0);
      chk("rnd_d1_pay",
          128'({bus.d1_ctrl, bus.d1_dest, bus.d1_op1, bus.d1_op2}),
          (e1 >= 0) ? pay(x1) : 128'(0));
      chk("rnd_count", count, mq.size());
      chk("rnd_full", full, mq.size() == DEPTH);
      chk("rnd_empty", empty, mq.size() == 0);

      flush = ($urandom_range(0, 31) == 0);
      bus.in_valid = ($urandom_range(0, 9) < 7);
      bus.in_ctrl = CTRL_W'($urandom);
      bus.in_dest = TAG_W'($urandom);
      bus.in_v1 = $urandom; bus.in_v2 = $urandom;
      bus.in_r1 = $urandom_range(0, 1);
      bus.in_r2 = $urandom_range(0, 1);
      bus.in_t1 = TAG_W'($urandom_range(0, 7));
      bus.in_t2 = TAG_W'($urandom_range(0, 7));
      bus.cdb0_valid = $urandom_range(0, 1);
      bus.cdb0_tag = TAG_W'($urandom_range(0, 7));
      bus.cdb0_data = $urandom;
      bus.cdb1_valid = $urandom_range(0, 1);
      bus.cdb1_tag = TAG_W'($urandom_range(0, 7));
      bus.cdb1_data = $urandom;
      bus.d0_ready = $urandom_range(0, 1);
      bus.d1_ready = $urandom_range(0, 1);
      model_step(e0, e1);
      tick();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
